// File: rtl/xpmwrap_fifo_wr_arbiter_if.sv
// Requester stream bundle plus the FIFO write-port signals shared by the write-side arbiter.
// The master modport is the arbiter's view; slave is the requester/FIFO side.
interface xpmwrap_fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  localparam int ID_WIDTH   = $clog2(NUM_REQ);
  localparam int FIFO_WIDTH = DATA_WIDTH + ID_WIDTH + 1;

  logic [NUM_REQ-1:0]            s_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_data;
  logic [NUM_REQ-1:0]            s_last;
  logic [NUM_REQ-1:0]            s_ready;
  logic [FIFO_WIDTH-1:0]         din;
  logic                          wr_en;
  logic                          full;
  logic                          wr_rst_busy;
  logic                          overflow;

  modport master (
    input  s_valid, s_data, s_last, full, wr_rst_busy, overflow,
    output s_ready, din, wr_en
  );

  modport slave (
    output s_valid, s_data, s_last, full, wr_rst_busy, overflow,
    input  s_ready, din, wr_en
  );
endinterface

// File: rtl/xpmwrap_fifo_wr_arbiter.sv
// Round-robin write-port arbiter: shares one async FIFO write port among NUM_REQ streams,
// holding each grant for a packet or MAX_BURST beats and tagging every word with {id, last}.
module xpmwrap_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                       wr_clk,
  input  logic                       rst,
  xpmwrap_fifo_wr_arbiter_if.master  bus,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       overflow_err
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);
  localparam int BEAT_W   = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0]   BEAT_MAX  = BEAT_W'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0] LAST_INIT = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0] last_id_q, last_id_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                overflow_err_q, overflow_err_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    valid_sh, last_sh;
  logic                  flow_ok, accept, final_beat;
  logic [ID_WIDTH:0]     idle_pick, next_pick;

  // Scan origin+1 .. origin+span (mod NUM_REQ) backwards so the nearest valid requester
  // is assigned last and wins; the wrap is a single subtraction so any NUM_REQ works.
  function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                input logic [ID_WIDTH-1:0] origin,
                                                input int span);
    logic [ID_WIDTH:0]  res;
    logic [NUM_REQ-1:0] sh;
    int                 idx;
    res = '0;
    for (int k = span; k >= 1; k--) begin
      idx = int'(origin) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sh = valid >> idx;
      if (sh[0]) res = {1'b1, ID_WIDTH'(idx)};
    end
    return res;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]    = bus.s_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign bus.s_ready[gi] = (state_q == BURST) && (grant_id_q == ID_WIDTH'(gi)) && flow_ok;
    end
  endgenerate

  assign flow_ok    = !bus.full && !bus.wr_rst_busy;
  assign valid_sh   = bus.s_valid >> grant_id_q;
  assign last_sh    = bus.s_last >> grant_id_q;
  assign accept     = (state_q == BURST) && valid_sh[0] && flow_ok;
  assign final_beat = last_sh[0] || (beat_cnt_q == BEAT_MAX);

  // Re-search after a final beat excludes the current grantee (span NUM_REQ-1).
  assign idle_pick = rr_pick(bus.s_valid, last_id_q, NUM_REQ);
  assign next_pick = rr_pick(bus.s_valid, grant_id_q, NUM_REQ - 1);

  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    last_id_d      = last_id_q;
    beat_cnt_d     = beat_cnt_q;
    overflow_err_d = overflow_err_q | bus.overflow;
    case (state_q)
      IDLE: begin
        if (idle_pick[ID_WIDTH] && !bus.wr_rst_busy) begin
          state_d    = BURST;
          grant_id_d = idle_pick[ID_WIDTH-1:0];
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (accept) begin
          if (final_beat) begin
            last_id_d  = grant_id_q;
            beat_cnt_d = '0;
            if (next_pick[ID_WIDTH]) grant_id_d = next_pick[ID_WIDTH-1:0];
            else                     state_d    = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      last_id_q      <= LAST_INIT;
      beat_cnt_q     <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      last_id_q      <= last_id_d;
      beat_cnt_q     <= beat_cnt_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  assign bus.wr_en    = accept;
  assign bus.din      = {grant_id_q, last_sh[0], data_arr[grant_id_q]};
  assign grant_valid  = (state_q == BURST);
  assign grant_id     = grant_id_q;
  assign overflow_err = overflow_err_q;
endmodule

// File: tb/tb_xpmwrap_fifo_wr_arbiter.sv
// Directed bench: requester queues feed the arbiter, a scoreboard checks every FIFO write.
module tb_xpmwrap_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int MB   = 5;
  localparam int IDW  = 2;
  localparam int FW   = DW + IDW + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           overflow_err;

  xpmwrap_fifo_wr_arbiter_if #(.NUM_REQ(NREQ), .DATA_WIDTH(DW)) bus ();

  xpmwrap_fifo_wr_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk      (clk),
    .rst         (rst),
    .bus         (bus),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [FW-1:0] exp_q [$];
  logic [DW:0]   rmem [NREQ][64];
  int            rhead [NREQ];
  int            rtail [NREQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] beat_data(input int r, input int tag, input int k);
    return DW'((r << 24) | (tag << 8) | k);
  endfunction

  task automatic refresh();
    for (int i = 0; i < NREQ; i++) begin
      if (rhead[i] != rtail[i]) begin
        bus.s_valid[i]          = 1'b1;
        bus.s_data[i*DW +: DW]  = rmem[i][rhead[i]][DW-1:0];
        bus.s_last[i]           = rmem[i][rhead[i]][DW];
      end else begin
        bus.s_valid[i]          = 1'b0;
        bus.s_data[i*DW +: DW]  = '0;
        bus.s_last[i]           = 1'b0;
      end
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    refresh();
  endtask

  task automatic send_pkt(input int r, input int n, input int tag);
    for (int k = 0; k < n; k++) begin
      rmem[r][rtail[r]] = {(k == n - 1), beat_data(r, tag, k)};
      rtail[r]++;
    end
    refresh();
  endtask

  // Expected words for beats k0..k1 of an n-beat packet from requester r.
  task automatic exp_beats(input int r, input int k0, input int k1, input int n, input int tag);
    for (int k = k0; k <= k1; k++)
      exp_q.push_back({IDW'(r), (k == n - 1), beat_data(r, tag, k)});
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < NREQ; i++) p += rtail[i] - rhead[i];
    return p;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.full = 1'b0;
    bus.wr_rst_busy = 1'b0;
    bus.overflow = 1'b0;
    clear_reqs();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || pending() != 0) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'(0));
    check({name, "_req_empty"}, 64'(pending()), 64'(0));
  endtask

  // Requester model: a beat leaves its queue only when valid and ready met at the edge.
  initial begin
    logic [NREQ-1:0] fire;
    forever begin
      @(negedge clk);
      #3;
      fire = bus.s_valid & bus.s_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (fire[i]) rhead[i]++;
      refresh();
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [FW-1:0] want;
    forever begin
      @(negedge clk);
      #3;
      if (bus.wr_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got din=%h required no write", bus.din);
        end else begin
          want = exp_q.pop_front();
          if (bus.din !== want) begin
            failures++;
            $display("FAIL sb_word: got din=%h required %h", bus.din, want);
          end else begin
            $display("write id=%0d last=%0d data=%h", bus.din[FW-1 -: IDW], bus.din[DW], bus.din[DW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  localparam logic [IDW-1:0] T2_IDS [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};

  initial begin
    bus.s_valid = '0;
    bus.s_data = '0;
    bus.s_last = '0;
    bus.full = 1'b0;
    bus.wr_rst_busy = 1'b0;
    bus.overflow = 1'b0;
    clear_reqs();
    tick();
    do_reset();

    // Reset state
    #1;
    check("rst_grant_valid", 64'(grant_valid), 64'(0));
    check("rst_wr_en", 64'(bus.wr_en), 64'(0));
    check("rst_s_ready", 64'(bus.s_ready), 64'(0));
    check("rst_overflow_err", 64'(overflow_err), 64'(0));
    check("rst_last_id", 64'(dut.last_id_q), 64'(3));
    check("rst_beat_cnt", 64'(dut.beat_cnt_q), 64'(0));

    // Single requester, 5-beat packet
    tick();
    send_pkt(0, 5, 1);
    exp_beats(0, 0, 4, 5, 1);
    #1;
    check("t1_ready_pre", 64'(bus.s_ready), 64'(0));
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      check("t1_ready", 64'(bus.s_ready), 64'(4'b0001));
      check("t1_wr_en", 64'(bus.wr_en), 64'(1));
    end
    tick();
    #1;
    check("t1_idle", 64'(grant_valid), 64'(0));
    check("t1_wr_en_off", 64'(bus.wr_en), 64'(0));
    wait_drain("t1");

    // Four requesters with 2-beat packets, requester 0 has a second one
    do_reset();
    send_pkt(0, 2, 1);
    send_pkt(1, 2, 1);
    send_pkt(2, 2, 1);
    send_pkt(3, 2, 1);
    send_pkt(0, 2, 2);
    exp_beats(0, 0, 1, 2, 1);
    exp_beats(1, 0, 1, 2, 1);
    exp_beats(2, 0, 1, 2, 1);
    exp_beats(3, 0, 1, 2, 1);
    exp_beats(0, 0, 1, 2, 2);
    for (int k = 0; k < 10; k++) begin
      tick();
      #1;
      check("t2_wr_en", 64'(bus.wr_en), 64'(1));
      check("t2_grant_id", 64'(grant_id), 64'(T2_IDS[k]));
    end
    tick();
    #1;
    check("t2_idle", 64'(grant_valid), 64'(0));
    wait_drain("t2");

    // MAX_BURST truncation: 10-beat packet from 1 split around requester 2
    do_reset();
    send_pkt(1, 10, 3);
    send_pkt(2, 2, 3);
    exp_beats(1, 0, 4, 10, 3);
    exp_beats(2, 0, 1, 2, 3);
    exp_beats(1, 5, 9, 10, 3);
    wait_drain("t3");

    // full held for 3 cycles mid-packet
    do_reset();
    send_pkt(0, 4, 4);
    exp_beats(0, 0, 3, 4, 4);
    tick();
    tick();
    tick();
    bus.full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t4_wr_en_full", 64'(bus.wr_en), 64'(0));
      check("t4_ready_full", 64'(bus.s_ready), 64'(0));
      check("t4_beat_cnt", 64'(dut.beat_cnt_q), 64'(2));
      check("t4_grant_id", 64'(grant_id), 64'(0));
      tick();
    end
    bus.full = 1'b0;
    wait_drain("t4");

    // wr_rst_busy after reset blocks the grant
    do_reset();
    bus.wr_rst_busy = 1'b1;
    send_pkt(2, 2, 5);
    exp_beats(2, 0, 1, 2, 5);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t5_no_grant", 64'(grant_valid), 64'(0));
      tick();
    end
    bus.wr_rst_busy = 1'b0;
    #1;
    check("t5_fall_cycle", 64'(grant_valid), 64'(0));
    tick();
    #1;
    check("t5_grant", 64'(grant_valid), 64'(1));
    check("t5_grant_id", 64'(grant_id), 64'(2));
    wait_drain("t5");

    // rst during beat 3 of 6, then overflow stickiness
    do_reset();
    send_pkt(0, 6, 6);
    exp_beats(0, 0, 2, 6, 6);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_reqs();
    #1;
    check("t6_grant_valid", 64'(grant_valid), 64'(0));
    check("t6_wr_en", 64'(bus.wr_en), 64'(0));
    check("t6_last_id", 64'(dut.last_id_q), 64'(3));
    tick();
    bus.overflow = 1'b1;
    tick();
    bus.overflow = 1'b0;
    #1;
    check("t6_ovf_set", 64'(overflow_err), 64'(1));
    tick();
    tick();
    #1;
    check("t6_ovf_hold", 64'(overflow_err), 64'(1));
    do_reset();
    #1;
    check("t6_ovf_clear", 64'(overflow_err), 64'(0));
    wait_drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
